// File: rtl/ir_decode_pipe_if.sv
//------------------------------------------------------------------------------
// Module      : ir_decode_pipe_if
// Description : Fetch-side handshake and decoded head-entry bus of ir_decode_pipe.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ir_decode_pipe_if #(
  parameter int IW   = 32,
  parameter int OPW  = 6,
  parameter int REGW = 5,
  parameter int XLEN = 32
);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [OPW-1:0]  opcode;
  logic [REGW-1:0] rz;
  logic [REGW-1:0] ry;
  logic [REGW-1:0] rx;
  logic [XLEN-1:0] imm;
  logic            uses_imm;
  logic            is_mem;
  logic            is_branch;
  logic            is_fp;
  logic            illegal;

  // Environment side: fetch producer plus downstream consumer
  modport master (
    output flush, in_valid, in_inst, out_ready,
    input  in_ready, out_valid, opcode, rz, ry, rx, imm,
           uses_imm, is_mem, is_branch, is_fp, illegal
  );

  modport slave (
    input  flush, in_valid, in_inst, out_ready,
    output in_ready, out_valid, opcode, rz, ry, rx, imm,
           uses_imm, is_mem, is_branch, is_fp, illegal
  );

endinterface

`default_nettype wire

// File: rtl/ir_decode_pipe.sv
//------------------------------------------------------------------------------
// Module      : ir_decode_pipe
// Description : 2-entry skid FIFO of instruction words, decoded on write.
//               Optional macro IR_ILLEGAL_TRAP_EN flags opcodes above JR..FPMULT.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ir_decode_pipe #(
  parameter int IW   = 32,
  parameter int OPW  = 6,
  parameter int REGW = 5,
  parameter int IMMW = 16,
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  ir_decode_pipe_if.slave   bus
);

  localparam logic [OPW-1:0] OP_ADDI   = OPW'(1);
  localparam logic [OPW-1:0] OP_SUBI   = OPW'(3);
  localparam logic [OPW-1:0] OP_ANDI   = OPW'(5);
  localparam logic [OPW-1:0] OP_ORI    = OPW'(7);
  localparam logic [OPW-1:0] OP_LDI    = OPW'(9);
  localparam logic [OPW-1:0] OP_LUI    = OPW'(10);
  localparam logic [OPW-1:0] OP_LW     = OPW'(11);
  localparam logic [OPW-1:0] OP_LWI    = OPW'(12);
  localparam logic [OPW-1:0] OP_SW     = OPW'(13);
  localparam logic [OPW-1:0] OP_SWI    = OPW'(14);
  localparam logic [OPW-1:0] OP_BNZ    = OPW'(15);
  localparam logic [OPW-1:0] OP_BPL    = OPW'(16);
  localparam logic [OPW-1:0] OP_JMP    = OPW'(17);
  localparam logic [OPW-1:0] OP_JAL    = OPW'(18);
  localparam logic [OPW-1:0] OP_JR     = OPW'(19);
  localparam logic [OPW-1:0] OP_FPADD  = OPW'(20);
  localparam logic [OPW-1:0] OP_FPMULT = OPW'(21);

  localparam logic [1:0] C_DEPTH = 2'd2;

  typedef struct packed {
    logic [OPW-1:0]  opcode;
    logic [REGW-1:0] rz;
    logic [REGW-1:0] ry;
    logic [REGW-1:0] rx;
    logic [XLEN-1:0] imm;
    logic            uses_imm;
    logic            is_mem;
    logic            is_branch;
    logic            is_fp;
    logic            illegal;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Field extraction and immediate extension of the incoming word
  // ---------------------------------------------------------------------------
  logic [OPW-1:0]    w_op;
  logic [REGW-1:0]   w_rz;
  logic [REGW-1:0]   w_ry;
  logic [REGW-1:0]   w_rx;
  logic [IMMW-1:0]   w_raw;
  logic [2*IMMW-1:0] w_lui;
  logic [XLEN-1:0]   w_imm_sext;
  logic [XLEN-1:0]   w_imm_zext;
  logic [XLEN-1:0]   w_imm_lui;

  assign w_op       = bus.in_inst[IW-1 -: OPW];
  assign w_rz       = bus.in_inst[IW-OPW-1 -: REGW];
  assign w_ry       = bus.in_inst[IW-OPW-REGW-1 -: REGW];
  assign w_rx       = bus.in_inst[IW-OPW-2*REGW-1 -: REGW];
  assign w_raw      = bus.in_inst[IMMW-1:0];
  assign w_lui      = {w_raw, {IMMW{1'b0}}};
  assign w_imm_sext = {{(XLEN-IMMW){w_raw[IMMW-1]}}, w_raw};
  assign w_imm_zext = XLEN'(w_raw);
  assign w_imm_lui  = XLEN'(w_lui);

  entry_t dec_d;

  always_comb begin
    dec_d           = '0;
    dec_d.opcode    = w_op;
    dec_d.rz        = w_rz;
    dec_d.ry        = w_ry;
    dec_d.uses_imm  = w_op inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_LDI,
                                   OP_LUI, OP_LWI, OP_SWI, OP_BNZ, OP_BPL,
                                   OP_JMP, OP_JAL};
    dec_d.is_mem    = w_op inside {OP_LW, OP_LWI, OP_SW, OP_SWI};
    dec_d.is_branch = w_op inside {OP_BNZ, OP_BPL, OP_JMP, OP_JAL, OP_JR};
    dec_d.is_fp     = w_op inside {OP_FPADD, OP_FPMULT};

    if (dec_d.uses_imm) begin
      if (w_op inside {OP_ANDI, OP_ORI, OP_LDI}) begin
        dec_d.imm = w_imm_zext;
      end else if (w_op == OP_LUI) begin
        dec_d.imm = w_imm_lui;
      end else begin
        dec_d.imm = w_imm_sext;
      end
    end else begin
      dec_d.rx = w_rx;
    end

`ifdef IR_ILLEGAL_TRAP_EN
    // Class flags are already clear for unmapped opcodes; only rx needs masking
    if (w_op > OP_FPMULT) begin
      dec_d.rx      = '0;
      dec_d.illegal = 1'b1;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  entry_t     mem_q [2];
  logic       rd_ptr_q;
  logic       rd_ptr_d;
  logic       wr_ptr_q;
  logic       wr_ptr_d;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       w_push;
  logic       w_pop;
  logic       w_in_ready;
  logic       w_out_valid;

  // Ready depends only on registered occupancy and flush, never on out_ready
  assign w_in_ready  = (count_q < C_DEPTH) && !bus.flush;
  assign w_out_valid = (count_q != 2'd0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (w_push) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (w_push) begin
        mem_q[wr_ptr_q] <= dec_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Head entry outputs, forced to zero while the FIFO is empty
  // ---------------------------------------------------------------------------
  entry_t w_head;

  assign w_head = w_out_valid ? mem_q[rd_ptr_q] : '0;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.opcode    = w_head.opcode;
  assign bus.rz        = w_head.rz;
  assign bus.ry        = w_head.ry;
  assign bus.rx        = w_head.rx;
  assign bus.imm       = w_head.imm;
  assign bus.uses_imm  = w_head.uses_imm;
  assign bus.is_mem    = w_head.is_mem;
  assign bus.is_branch = w_head.is_branch;
  assign bus.is_fp     = w_head.is_fp;
  assign bus.illegal   = w_head.illegal;

endmodule

`default_nettype wire

// File: tb/tb_ir_decode_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_ir_decode_pipe
// Description : Self-checking bench for ir_decode_pipe against a queue model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ir_decode_pipe;

  logic clk;
  logic rst_n;

  ir_decode_pipe_if #(.IW(32), .OPW(6), .REGW(5), .XLEN(32)) bus ();

  ir_decode_pipe #(
    .IW   (32),
    .OPW  (6),
    .REGW (5),
    .IMMW (16),
    .XLEN (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rz;
    logic [4:0]  ry;
    logic [4:0]  rx;
    logic [31:0] imm;
    logic        uses_imm;
    logic        is_mem;
    logic        is_branch;
    logic        is_fp;
    logic        illegal;
  } dec_t;

  int          n_checks;
  int          n_errors;
  logic [31:0] q[$];
  logic        cur_flush;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the opcode table
  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t        d;
    int          op;
    logic [15:0] raw;
    d          = '0;
    op         = int'(w[31:26]);
    raw        = w[15:0];
    d.opcode   = w[31:26];
    d.rz       = w[25:21];
    d.ry       = w[20:16];
    d.uses_imm = op inside {1, 3, 5, 7, 9, 10, 12, 14, 15, 16, 17, 18};
    d.is_mem   = op inside {11, 12, 13, 14};
    d.is_branch = op inside {15, 16, 17, 18, 19};
    d.is_fp    = op inside {20, 21};
    if (d.uses_imm) begin
      if (op inside {5, 7, 9})  d.imm = {16'h0000, raw};
      else if (op == 10)        d.imm = {raw, 16'h0000};
      else                      d.imm = 32'($signed(raw));
    end else begin
      d.rx = w[15:11];
    end
`ifdef IR_ILLEGAL_TRAP_EN
    if (op > 21) begin
      d.rx      = 5'd0;
      d.illegal = 1'b1;
    end
`endif
    return d;
  endfunction

  task automatic check_head(input logic with_ready);
    dec_t e;
    e = (q.size() != 0) ? ref_dec(q[0]) : '0;
    check_eq("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    if (with_ready)
      check_eq("in_ready", 64'(bus.in_ready), 64'((q.size() < 2) && !cur_flush));
    check_eq("opcode",    64'(bus.opcode),    64'(e.opcode));
    check_eq("rz",        64'(bus.rz),        64'(e.rz));
    check_eq("ry",        64'(bus.ry),        64'(e.ry));
    check_eq("rx",        64'(bus.rx),        64'(e.rx));
    check_eq("imm",       64'(bus.imm),       64'(e.imm));
    check_eq("uses_imm",  64'(bus.uses_imm),  64'(e.uses_imm));
    check_eq("is_mem",    64'(bus.is_mem),    64'(e.is_mem));
    check_eq("is_branch", 64'(bus.is_branch), 64'(e.is_branch));
    check_eq("is_fp",     64'(bus.is_fp),     64'(e.is_fp));
    check_eq("illegal",   64'(bus.illegal),   64'(e.illegal));
  endtask

  // Entered and left 1 time unit after a rising edge
  task automatic step(input logic v, input logic [31:0] inst, input logic rdy, input logic fl);
    logic do_push;
    logic do_pop;
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.out_ready = rdy;
    bus.flush     = fl;
    cur_flush     = fl;
    @(negedge clk);
    check_head(1'b1);
    do_push = v && (q.size() < 2) && !fl;
    do_pop  = (q.size() != 0) && rdy;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(inst);
    end
    #1;
  endtask

  function automatic logic [31:0] mk(input int op, input int rz, input int ry, input logic [15:0] lo);
    return {6'(op), 5'(rz), 5'(ry), lo};
  endfunction

  initial begin
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    n_checks      = 0;
    n_errors      = 0;
    cur_flush     = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    #12;
    check_head(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_head(1'b1);

    // ADDI with negative immediate
    step(1'b1, 32'h0441FFF0, 1'b0, 1'b0);
    check_eq("addi_opcode", 64'(bus.opcode),   64'd1);
    check_eq("addi_rz",     64'(bus.rz),       64'd2);
    check_eq("addi_ry",     64'(bus.ry),       64'd1);
    check_eq("addi_rx",     64'(bus.rx),       64'd0);
    check_eq("addi_imm",    64'(bus.imm),      64'hFFFFFFF0);
    check_eq("addi_uimm",   64'(bus.uses_imm), 64'd1);
    step(1'b0, '0, 1'b1, 1'b0);

    step(1'b1, mk(5, 2, 1, 16'hFFF0), 1'b0, 1'b0);
    check_eq("andi_imm", 64'(bus.imm), 64'h0000FFF0);
    step(1'b1, mk(10, 3, 4, 16'h1234), 1'b1, 1'b0);
    check_eq("lui_imm", 64'(bus.imm), 64'h12340000);
    step(1'b1, 32'h00221800, 1'b1, 1'b0);
    check_eq("add_rx",   64'(bus.rx),       64'd3);
    check_eq("add_imm",  64'(bus.imm),      64'd0);
    check_eq("add_uimm", 64'(bus.uses_imm), 64'd0);
    step(1'b1, mk(21, 1, 2, 16'h1800), 1'b1, 1'b0);
    check_eq("fpmult_fp", 64'(bus.is_fp), 64'd1);
    step(1'b1, mk(19, 7, 0, 16'h0000), 1'b1, 1'b0);
    check_eq("jr_branch", 64'(bus.is_branch), 64'd1);
    check_eq("jr_uimm",   64'(bus.uses_imm),  64'd0);
    step(1'b1, mk(63, 1, 2, 16'h1FFF), 1'b1, 1'b0);
`ifdef IR_ILLEGAL_TRAP_EN
    check_eq("op3f_illegal", 64'(bus.illegal), 64'd1);
    check_eq("op3f_rx",      64'(bus.rx),      64'd0);
`else
    check_eq("op3f_illegal", 64'(bus.illegal), 64'd0);
    check_eq("op3f_rx",      64'(bus.rx),      64'd3);
`endif
    check_eq("op3f_flags", 64'({bus.uses_imm, bus.is_mem, bus.is_branch, bus.is_fp}), 64'd0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: three offered, two accepted, head held
    w1 = mk(1, 1, 1, 16'h0001);
    w2 = mk(2, 2, 2, 16'h1000);
    w3 = mk(3, 3, 3, 16'h8003);
    step(1'b1, w1, 1'b0, 1'b0);
    step(1'b1, w2, 1'b0, 1'b0);
    step(1'b1, w3, 1'b0, 1'b0);
    check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("bp_head",     64'(bus.opcode),   64'd1);
    step(1'b1, w3, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_eq("bp_second", 64'(bus.opcode), 64'd2);
    step(1'b1, w3, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush while full with a word offered
    step(1'b1, w1, 1'b0, 1'b0);
    step(1'b1, w2, 1'b0, 1'b0);
    step(1'b1, w3, 1'b0, 1'b1);
    check_eq("flush_valid", 64'(bus.out_valid), 64'd0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset with two entries buffered
    step(1'b1, w1, 1'b0, 1'b0);
    step(1'b1, w2, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    check_head(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) != 0)
        w[31:26] = 6'($urandom_range(0, 21));
      step(($urandom_range(0, 9) < 7), w, ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ir_decode_pipe.md
# ir_decode_pipe

Registered, parametrised successor to the combinational instruction register: accepts fetched instruction words over a valid/ready handshake and buffers them in a 2-entry skid FIFO. Each entry is decoded into opcode, register indices, extended immediate and class flags at write time. Sits between fetch and the register-file/ALU stage. Stalls fetch without dropping words and supports a pipeline flush on taken branches and jumps.

## Interface
- IW, 32, instruction word width (≥ OPW+3·REGW)
- OPW, 6, opcode width, field at [IW-1 -: OPW]
- REGW, 5, register index width; Rz at [IW-OPW-1 -: REGW], Ry next below, Rx next below that
- IMMW, 16, raw immediate width, field at [IMMW-1:0]
- XLEN, 32, extended immediate width (≥ 2·IMMW)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all buffered entries
- in_valid  in  1  in_inst valid
- in_ready  out  1  block can accept a word
- in_inst  in  IW  instruction word
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head
- opcode  out  OPW  head opcode
- rz, ry, rx  out  REGW each  head register indices
- imm  out  XLEN  head extended immediate
- uses_imm, is_mem, is_branch, is_fp  out  1 each  head class flags
- illegal  out  1  head opcode undefined (see Configuration)

## Operation
- Opcode map: ADD 0, ADDI 1, SUB 2, SUBI 3, AND 4, ANDI 5, OR 6, ORI 7, COM 8, LDI 9, LUI 10, LW 11, LWI 12, SW 13, SWI 14, BNZ 15, BPL 16, JMP 17, JAL 18, JR 19, FPADD 20, FPMULT 21.
- Immediate class (uses_imm=1): ADDI, SUBI, ANDI, ORI, LDI, LUI, LWI, SWI, BNZ, BPL, JMP, JAL. For these rx=0; for all others rx=Rx field and imm=0.
- Extension: ANDI, ORI, LDI zero-extend; LUI places raw imm at [2·IMMW-1:IMMW], zeros elsewhere; remaining immediate opcodes sign-extend from bit IMMW-1.
- Flags: is_mem for LW, LWI, SW, SWI; is_branch for BNZ, BPL, JMP, JAL, JR; is_fp for FPADD, FPMULT.
- Decode happens on write; outputs come straight from the head entry's registers.
- FIFO: 2 entries, strict order. Push when in_valid && in_ready; pop when out_valid && out_ready.
- in_ready = (count < 2) && !flush. Full with simultaneous pop still reports in_ready=0; no combinational ready path.
- flush: count←0 at next edge, overrides push and pop; the word presented that cycle is not accepted.
- When out_valid=0, all decoded outputs are held at 0.

## Timing
- Reset (rst_n low, asynchronous): count=0, out_valid=0, in_ready=1 once released; opcode, rz, ry, rx, imm, all flags and illegal = 0.
- Latency: a word pushed into an empty FIFO at edge N drives out_valid=1 with decoded fields after edge N.
- Throughput: 1 word/cycle with out_ready held high.
- Count=1 with push and pop in the same cycle: count stays 1; the new word becomes head.
- Head outputs stay stable while out_valid && !out_ready.
- Reset asserted mid-transfer: all entries are discarded immediately and nothing is replayed.

## Configuration
- IR_ILLEGAL_TRAP_EN defined: opcodes > 21 set illegal=1, uses_imm=0, imm=0, rx=0, and all other flags 0; the entry is still delivered in order.
- IR_ILLEGAL_TRAP_EN undefined: illegal is tied to 0; undefined opcodes decode as register type (rx=Rx field, imm=0, flags 0).

## Test plan
- Reset mid-stream: 2 entries buffered, pulse rst_n low -> out_valid=0 and all outputs 0 asynchronously; in_ready=1 after release.
- ADDI, imm 0xFFF0 (inst 0x0441FFF0) -> opcode=1, rz=2, ry=1, rx=0, imm=0xFFFFFFF0, uses_imm=1; ANDI 0xFFF0 -> imm=0x0000FFF0; LUI 0x1234 -> imm=0x12340000.
- ADD, Rx=3 (0x00221800) -> rx=3, imm=0, uses_imm=0; FPMULT -> is_fp=1; JR -> is_branch=1, uses_imm=0.
- Backpressure: out_ready=0 with 3 words offered -> first 2 accepted, in_ready=0, head stable; raise out_ready -> words delivered in order, 1 per cycle.
- flush with count=2 and in_valid=1 -> next cycle out_valid=0, count=0, offered word not accepted.
- Opcode 0x3F: with IR_ILLEGAL_TRAP_EN -> illegal=1, flags 0; without it -> illegal=0, treated as register type.
